// File: rtl/btn_event_ctrl.sv
// Click classifier for debounced push-button pulses: SINGLE/DOUBLE events queued in a FIFO.
// Optional EV_TIMESTAMP_EN adds a 16-bit tick stamp per event on ev_ts.
module btn_event_ctrl #(
   parameter int TICK_DIV     = 100000,
   parameter int DCLICK_TICKS = 300,
   parameter int FIFO_AW      = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pb_in,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic [1:0]       ev_code,
   output logic [CNT_W-1:0] press_cnt,
   output logic             ovf,
   input  logic             clr_ovf
`ifdef EV_TIMESTAMP_EN
   ,
   output logic [15:0]      ev_ts
`endif
);

   localparam int PW    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int TW    = $clog2(DCLICK_TICKS + 1);
   localparam int DEPTH = 1 << FIFO_AW;
`ifdef EV_TIMESTAMP_EN
   localparam int EW    = 18;
`else
   localparam int EW    = 2;
`endif

   localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
   localparam logic [TW-1:0] TIMER_LOAD = TW'(DCLICK_TICKS);
   localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
   localparam logic [1:0]    EV_NONE    = 2'b00;
   localparam logic [1:0]    EV_SINGLE  = 2'b01;
   localparam logic [1:0]    EV_DOUBLE  = 2'b10;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_WINDOW = 1'b1
   } state_t;

   logic               pb_q_r;
   logic               rise_s;
   logic [PW-1:0]      presc_r;
   logic               tick_s;
   state_t             state_r;
   state_t             state_nxt_s;
   logic [TW-1:0]      timer_r;
   logic [TW-1:0]      timer_nxt_s;
   logic               push_s;
   logic [1:0]         push_code_s;
   logic [FIFO_AW:0]   wr_ptr_r;
   logic [FIFO_AW:0]   rd_ptr_r;
   logic [FIFO_AW:0]   wr_ptr_nxt_s;
   logic [FIFO_AW:0]   rd_ptr_nxt_s;
   logic               empty_s;
   logic               full_s;
   logic               empty_nxt_s;
   logic               pop_s;
   logic               push_ok_s;
   logic               drop_s;
   logic [EW-1:0]      mem_r [DEPTH];
   logic [EW-1:0]      push_entry_s;
   logic [EW-1:0]      head_nxt_s;
   logic               ev_valid_r;
   logic [1:0]         ev_code_r;
   logic [CNT_W-1:0]   press_cnt_r;
   logic               ovf_r;
`ifdef EV_TIMESTAMP_EN
   logic [15:0]        ts_r;
   logic [15:0]        ts_nxt_s;
   logic [15:0]        ev_ts_r;
`endif

   assign rise_s    = pb_in & ~pb_q_r;
   assign tick_s    = (presc_r == PRESC_MAX);
   assign ev_valid  = ev_valid_r;
   assign ev_code   = ev_code_r;
   assign press_cnt = press_cnt_r;
   assign ovf       = ovf_r;
`ifdef EV_TIMESTAMP_EN
   assign ev_ts     = ev_ts_r;
`endif

   // Edge detector and wrapping press counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pb_q_r      <= 1'b0;
         press_cnt_r <= CNT_W'(0);
      end else begin
         pb_q_r <= pb_in;
         if (rise_s) begin
            press_cnt_r <= press_cnt_r + CNT_W'(1);
         end
      end
   end

   // Free-running window prescaler; never restarted by a press
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_r <= PW'(0);
      end else if (tick_s) begin
         presc_r <= PW'(0);
      end else begin
         presc_r <= presc_r + PW'(1);
      end
   end

`ifdef EV_TIMESTAMP_EN
   // Stamp includes the tick of the push cycle so an expiry on tick N reads N
   always_comb begin
      ts_nxt_s = ts_r;
      if (tick_s) begin
         ts_nxt_s = ts_r + 16'd1;
      end else begin
         ts_nxt_s = ts_r;
      end
   end

   // Free-running tick counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ts_r <= 16'd0;
      end else begin
         ts_r <= ts_nxt_s;
      end
   end

   assign push_entry_s = {ts_nxt_s, push_code_s};
`else
   assign push_entry_s = push_code_s;
`endif

   // Click-window FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         timer_r <= TW'(0);
      end else begin
         state_r <= state_nxt_s;
         timer_r <= timer_nxt_s;
      end
   end

   // Click-window next state; a second press beats a same-cycle expiry
   always_comb begin
      state_nxt_s = state_r;
      timer_nxt_s = timer_r;
      push_s      = 1'b0;
      push_code_s = EV_NONE;
      case (state_r)
         ST_IDLE: begin
            if (rise_s) begin
               state_nxt_s = ST_WINDOW;
               timer_nxt_s = TIMER_LOAD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WINDOW: begin
            if (rise_s) begin
               push_s      = 1'b1;
               push_code_s = EV_DOUBLE;
               state_nxt_s = ST_IDLE;
            end else if (tick_s) begin
               if (timer_r == TIMER_ONE) begin
                  push_s      = 1'b1;
                  push_code_s = EV_SINGLE;
                  state_nxt_s = ST_IDLE;
               end else begin
                  timer_nxt_s = timer_r - TW'(1);
               end
            end else begin
               state_nxt_s = ST_WINDOW;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            timer_nxt_s = TW'(0);
         end
      endcase
   end

   // FIFO control and the head entry as it will look after this edge
   always_comb begin
      empty_s      = (wr_ptr_r == rd_ptr_r);
      full_s       = (wr_ptr_r[FIFO_AW] != rd_ptr_r[FIFO_AW]) &&
                     (wr_ptr_r[FIFO_AW-1:0] == rd_ptr_r[FIFO_AW-1:0]);
      pop_s        = ~empty_s & ev_ready;
      push_ok_s    = push_s & (~full_s | pop_s);
      drop_s       = push_s & full_s & ~pop_s;
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      if (push_ok_s) begin
         wr_ptr_nxt_s = wr_ptr_r + {{FIFO_AW{1'b0}}, 1'b1};
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
         rd_ptr_nxt_s = rd_ptr_r + {{FIFO_AW{1'b0}}, 1'b1};
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end
      empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
      // Write slot equals the next head slot only when the FIFO was empty after the pop
      if (push_ok_s && (wr_ptr_r[FIFO_AW-1:0] == rd_ptr_nxt_s[FIFO_AW-1:0])) begin
         head_nxt_s = push_entry_s;
      end else begin
         head_nxt_s = mem_r[rd_ptr_nxt_s[FIFO_AW-1:0]];
      end
   end

   // FIFO storage and pointers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r <= {(FIFO_AW+1){1'b0}};
         rd_ptr_r <= {(FIFO_AW+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {EW{1'b0}};
         end
      end else begin
         wr_ptr_r <= wr_ptr_nxt_s;
         rd_ptr_r <= rd_ptr_nxt_s;
         if (push_ok_s) begin
            mem_r[wr_ptr_r[FIFO_AW-1:0]] <= push_entry_s;
         end
      end
   end

   // Registered consumer-side outputs and sticky overflow
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ev_valid_r <= 1'b0;
         ev_code_r  <= EV_NONE;
         ovf_r      <= 1'b0;
`ifdef EV_TIMESTAMP_EN
         ev_ts_r    <= 16'd0;
`endif
      end else begin
         ev_valid_r <= ~empty_nxt_s;
         ev_code_r  <= empty_nxt_s ? EV_NONE : head_nxt_s[1:0];
`ifdef EV_TIMESTAMP_EN
         ev_ts_r    <= empty_nxt_s ? 16'd0 : head_nxt_s[17:2];
`endif
         if (drop_s) begin
            ovf_r <= 1'b1;
         end else if (clr_ovf) begin
            ovf_r <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Self-checking bench for btn_event_ctrl: vector table, scoreboard of expected events, corner sequences.
module tb_btn_event_ctrl;

   localparam int TICK_DIV = 10;
   localparam int DCLICK   = 5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pb_in;
   logic        ev_valid;
   logic        ev_ready;
   logic [1:0]  ev_code;
   logic [15:0] press_cnt;
   logic        ovf;
   logic        clr_ovf;
`ifdef EV_TIMESTAMP_EN
   logic [15:0] ev_ts;
`endif

   btn_event_ctrl #(
      .TICK_DIV(TICK_DIV), .DCLICK_TICKS(DCLICK), .FIFO_AW(2), .CNT_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pb_in(pb_in),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
      .press_cnt(press_cnt), .ovf(ovf), .clr_ovf(clr_ovf)
`ifdef EV_TIMESTAMP_EN
      , .ev_ts(ev_ts)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int         npulse;
      int         width;
      int         gap;
      logic [1:0] exp0;
      logic [1:0] exp1;
   } vec_t;

   vec_t       vecs[6];
   logic [1:0] exp_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         exp_cnt  = 0;
   int         cyc      = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: score any handshake seen before the edge, then return just after the edge.
   // cyc afterwards is the index of the next posedge counted from reset release.
   task automatic step();
      logic r;
      logic [1:0] e;
      @(negedge clk);
      if (ev_valid && ev_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got code %0b, expected no event (t=%0t)", ev_code, $time);
         end else begin
            e = exp_q.pop_front();
            chk("event_code", {30'd0, ev_code}, {30'd0, e});
         end
      end
      r = rst_n;
      @(posedge clk);
      #1;
      cyc = r ? cyc + 1 : 0;
   endtask

   task automatic pulse(input int w);
      pb_in = 1'b1;
      repeat (w) step();
      pb_in = 1'b0;
      exp_cnt++;
   endtask

   initial begin
      int k0;
      int t1;
      int p;
      int guard;

      vecs[0] = '{npulse: 1, width: 3,  gap: 0,  exp0: 2'b01, exp1: 2'b00};
      vecs[1] = '{npulse: 2, width: 3,  gap: 20, exp0: 2'b10, exp1: 2'b00};
      vecs[2] = '{npulse: 2, width: 1,  gap: 3,  exp0: 2'b10, exp1: 2'b00};
      vecs[3] = '{npulse: 1, width: 40, gap: 0,  exp0: 2'b01, exp1: 2'b00};
      vecs[4] = '{npulse: 2, width: 2,  gap: 60, exp0: 2'b01, exp1: 2'b01};
      vecs[5] = '{npulse: 2, width: 2,  gap: 35, exp0: 2'b10, exp1: 2'b00};

      rst_n = 1'b0; pb_in = 1'b0; ev_ready = 1'b0; clr_ovf = 1'b0;
      step(); step();
      chk("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
      chk("rst_ev_code", {30'd0, ev_code}, 32'd0);
      chk("rst_press_cnt", {16'd0, press_cnt}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
      rst_n = 1'b1;
      step();

      // Table-driven click patterns, consumer always ready
      ev_ready = 1'b1;
      for (int v = 0; v < 6; v++) begin
         exp_q.push_back(vecs[v].exp0);
         if (vecs[v].exp1 != 2'b00) exp_q.push_back(vecs[v].exp1);
         pulse(vecs[v].width);
         if (vecs[v].npulse == 2) begin
            repeat (vecs[v].gap - vecs[v].width) step();
            pulse(vecs[v].width);
         end
         repeat (70) step();
         chk("vec_all_events_seen", exp_q.size(), 32'd0);
         chk("vec_press_cnt", {16'd0, press_cnt}, exp_cnt);
         chk("vec_ev_valid_idle", {31'd0, ev_valid}, 32'd0);
      end

      // Overflow: five singles with no consumer, fifth dropped
      ev_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp_q.push_back(2'b01);
         pulse(3);
         repeat (97) step();
      end
      chk("ovf_ev_valid", {31'd0, ev_valid}, 32'd1);
      chk("ovf_head_code", {30'd0, ev_code}, 32'd1);
      chk("ovf_set", {31'd0, ovf}, 32'd1);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      chk("ovf_cleared", {31'd0, ovf}, 32'd0);
      ev_ready = 1'b1;
      repeat (6) step();
      ev_ready = 1'b0;
      chk("ovf_drained", exp_q.size(), 32'd0);
      chk("ovf_empty_valid", {31'd0, ev_valid}, 32'd0);
      chk("ovf_empty_code", {30'd0, ev_code}, 32'd0);

      // Full FIFO: pop on the exact cycle a new SINGLE is pushed
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(2'b01);
         pulse(3);
         repeat (97) step();
      end
      k0 = cyc;
      t1 = k0 - (k0 % TICK_DIV) + TICK_DIV - 1;
      if (t1 <= k0) t1 = t1 + TICK_DIV;
      p = t1 + (DCLICK - 1) * TICK_DIV;
      exp_q.push_back(2'b01);
      pulse(3);
      guard = 0;
      while (cyc != p && guard < 200) begin
         step();
         guard++;
      end
      chk("full_wait_in_budget", {31'd0, (cyc == p)}, 32'd1);
      ev_ready = 1'b1;
      step();
      ev_ready = 1'b0;
      repeat (3) step();
      chk("full_pushpop_no_ovf", {31'd0, ovf}, 32'd0);
      chk("full_pushpop_valid", {31'd0, ev_valid}, 32'd1);
      chk("full_pushpop_pending", exp_q.size(), 32'd4);
      ev_ready = 1'b1;
      repeat (8) step();
      chk("full_drained", exp_q.size(), 32'd0);
      chk("full_empty_valid", {31'd0, ev_valid}, 32'd0);

      // Reset mid-window discards the pending press
      pulse(3);
      repeat (17) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      exp_cnt = 0;
      repeat (80) step();
      chk("midrst_no_event", {31'd0, ev_valid}, 32'd0);
      chk("midrst_press_cnt", {16'd0, press_cnt}, 32'd0);

      // Click on the first cycle after reset; expiry on the fifth tick
      ev_ready = 1'b0;
      rst_n = 1'b0;
      pb_in = 1'b1;
      step();
      rst_n = 1'b1;
      repeat (3) step();
      pb_in = 1'b0;
      exp_q.push_back(2'b01);
      repeat (55) step();
      chk("stamp_valid", {31'd0, ev_valid}, 32'd1);
      chk("stamp_code", {30'd0, ev_code}, 32'd1);
      chk("stamp_press_cnt", {16'd0, press_cnt}, 32'd1);
`ifdef EV_TIMESTAMP_EN
      chk("stamp_ev_ts", {16'd0, ev_ts}, 32'd5);
`endif
      ev_ready = 1'b1;
      repeat (3) step();
      chk("stamp_drained", exp_q.size(), 32'd0);
      chk("stamp_empty_code", {30'd0, ev_code}, 32'd0);
`ifdef EV_TIMESTAMP_EN
      chk("stamp_empty_ts", {16'd0, ev_ts}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/btn_event_ctrl.md
Name: btn_event_ctrl

Overview:
- Sits directly downstream of the push-button debouncer. Consumes its debounced press pulse `pb_in`, one per physical press, high for one or more `clk` cycles.
- Classifies presses into SINGLE and DOUBLE click events using a millisecond-granular click window.
- Queues events in a small FIFO, drained by the picoVersat I/O side through a valid/ready handshake.
- Also keeps a wrapping press counter and a sticky overflow flag.

Parameters:
- TICK_DIV, 100000: `clk` cycles per window tick (1 ms at 100 MHz). Must be >= 2.
- DCLICK_TICKS, 300: click window length in ticks. Must be >= 1.
- FIFO_AW, 2: FIFO address width; depth = 2**FIFO_AW.
- CNT_W, 16: width of `press_cnt`.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- pb_in  in  1  debounced press pulse from debouncer, same clock domain
- ev_valid  out  1  FIFO not empty
- ev_ready  in  1  consumer accepts head event
- ev_code  out  2  head event: 01 SINGLE, 10 DOUBLE, 00 when empty
- press_cnt  out  CNT_W  total rising edges of `pb_in` since reset
- ovf  out  1  sticky: an event was dropped on a full FIFO
- clr_ovf  in  1  clears `ovf`

Behaviour:
- Reset (`rst_n`=0 at posedge clk):
  - Outputs: `ev_valid`=0, `ev_code`=00, `press_cnt`=0, `ovf`=0.
  - Internal: FIFO empty, FSM=IDLE, tick prescaler=0, window timer=0, `pb_in` delay register=0.
  - Reset mid-window discards the pending press; no event is emitted.
- Edge detect: `pb_q` <= `pb_in`; `rise` = `pb_in` & ~`pb_q`. A pulse held many cycles counts once.
- `press_cnt` increments on every `rise`, wrapping 2**CNT_W-1 -> 0.
- Tick generator:
  - Free-running prescaler 0..TICK_DIV-1.
  - `tick`=1 for one cycle when the prescaler equals TICK_DIV-1, then it wraps to 0.
- FSM states IDLE, WINDOW:
  - IDLE, `rise` -> WINDOW; timer loaded with DCLICK_TICKS.
  - WINDOW, `rise` -> push DOUBLE, go IDLE.
  - WINDOW, `tick` with timer=1 -> push SINGLE, go IDLE.
  - WINDOW, other `tick` -> timer decrements.
  - WINDOW, `rise` and expiry in the same cycle -> DOUBLE wins; no SINGLE is pushed.
  - Window is therefore DCLICK_TICKS ticks, with -1 tick uncertainty (the prescaler is not restarted).
- Push latency: the event appears at the FIFO head and `ev_valid` rises on the cycle after the push decision (registered FIFO state).
- FIFO:
  - Pop when `ev_valid` & `ev_ready`.
  - `ev_code` and `ev_valid` are stable while `ev_valid`=1 and `ev_ready`=0.
  - Push when full without pop: event dropped, `ovf` <= 1.
  - Push and pop in the same cycle when full: both accepted, no overflow.
  - Push and pop in the same cycle when empty: pop ignored, push accepted.
  - `ev_ready` while empty: no effect.
- `ovf`:
  - Set has priority over `clr_ovf` in the same cycle.
  - `clr_ovf` alone clears it the next cycle.
- Pointers are FIFO_AW+1 bits; full/empty are derived from the MSB compare.

Optional Feature:
- Macro: EV_TIMESTAMP_EN.
- Defined:
  - Adds output `ev_ts` (16 bits) and a 16-bit free-running tick counter, reset to 0, incremented on each `tick`, wrapping at 65535.
  - Each FIFO entry stores the counter value at push time; `ev_ts` shows the head entry's stamp.
  - `ev_ts` is 0 when empty.
- Undefined: no `ev_ts` port, no counter, FIFO entries are 2 bits.

Test Plan:
- Use TICK_DIV=10, DCLICK_TICKS=5, FIFO_AW=2, CNT_W=16 for all scenarios.
- Single click: one `pb_in` pulse 3 cycles wide, `ev_ready`=0 -> after about 50 cycles, exactly one SINGLE (`ev_code`=01, `ev_valid`=1); `press_cnt`=1.
- Double click: two pulses 20 cycles apart -> one DOUBLE (10), no SINGLE; `press_cnt`=2.
- Overflow: 5 single clicks spaced 100 cycles, `ev_ready`=0 -> `ev_valid`=1, 4 entries held, `ovf`=1. Pulse `clr_ovf` -> `ovf`=0. Drain 4 -> `ev_valid`=0.
- Full push+pop: FIFO holds 4 entries; hold `ev_ready`=1 on the exact cycle a new SINGLE is pushed -> `ovf` stays 0, occupancy stays 4. Edge case, covered alongside the other scenarios.
- Reset mid-window: pulse, then `rst_n`=0 for 1 cycle at +20 cycles -> no event ever emitted; `press_cnt`=0.
- EV_TIMESTAMP_EN: a click at cycle 0 from reset, window expiring after the 5th tick -> `ev_ts`=5 with the SINGLE.
